branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer-side partner of the 2-bit direction predictor. It holds in-flight predictions issued at fetch and checks each one, in order, against the outcome resolved in execute. It produces the flush and redirect to the front end, and drives the training strobes (branch-valid, actual-taken) back into the predictor. It sits between the fetch stage, the execute-stage branch comparator and the predictor.

Parameters:
DEPTH, 4, in-flight prediction FIFO entries (power of 2, ≥2)
XLEN, 32, PC width
FLUSH_CYCLES, 2, cycles the front end is held in recovery after a mispredict (≥1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
pred_valid  in  1  fetch issues a conditional branch this cycle
pred_taken  in  1  predictor direction for that branch
pred_pc  in  XLEN  branch PC
pred_target  in  XLEN  predicted target, used only if pred_taken
res_valid  in  1  execute resolves the oldest in-flight branch
res_taken  in  1  actual direction
res_target  in  XLEN  actual taken target
full  out  1  FIFO full; fetch must not issue a branch
stall_fetch  out  1  high in RECOVER
flush  out  1  one-cycle pulse on mispredict
redirect_pc  out  XLEN  correct next PC, valid while flush=1
upd_valid  out  1  training strobe to predictor (Br_x)
upd_taken  out  1  actual outcome to predictor (BrTrue)
err_underflow  out  1  sticky: res_valid seen with FIFO empty

Behaviour:
- Reset (rst=0, async): FIFO empty, state RUN. flush, upd_valid, upd_taken, stall_fetch and err_underflow are 0. redirect_pc is 0.
- FIFO entry holds {taken, pc, target}. Push on pred_valid && !full && state==RUN. Pop on res_valid && !empty && state==RUN.
- Push and pop in the same cycle are both performed; the count is unchanged. A push with full=1 is dropped. Pointers wrap modulo DEPTH.
- Mispredict at pop when either:
  - head.taken != res_taken, or
  - head.taken && res_taken && head.target != res_target.
- Outputs are registered, one cycle after res_valid:
  - upd_valid=1 and upd_taken=res_taken on every valid pop, whether correct or mispredicted.
  - On mispredict: flush=1 for one cycle. redirect_pc = res_taken ? res_target : head.pc+4, wrapping modulo 2^XLEN.
- Mispredict in the same cycle as a push: the push is discarded as wrong-path. The whole FIFO, including younger entries, is cleared on the registered edge.
- FSM:
  - RUN -> RECOVER on mispredict. A counter is loaded with FLUSH_CYCLES.
  - RECOVER: stall_fetch=1. Counter decrements each cycle. Go to RUN when it reaches 1.
  - In RECOVER, pred_valid and res_valid are ignored: no push, no pop, no training, no error.
- Correct prediction: no flush, no state change.
- res_valid with FIFO empty in RUN: no training. err_underflow is set and stays set until reset.
- Reset asserted mid-RECOVER or mid-flush returns to RUN with empty FIFO and all outputs 0 immediately.

Optional Feature:
BR_STATS_EN. When defined, adds two outputs:
- br_count: 32-bit count of valid pops.
- mispred_count: 32-bit count of mispredicts.
Both are cleared by reset, increment on the same edge as upd_valid/flush, and wrap at 2^32. Without the macro, these ports and registers are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then no stimulus -> all outputs 0, full=0 throughout.
- Push {taken=1, pc=0x100, target=0x200}; resolve taken with 0x200 -> next cycle upd_valid=1, upd_taken=1, flush=0.
- Push {taken=0, pc=0x100}; resolve taken with 0x180 -> flush=1, redirect_pc=0x180. Then stall_fetch=1 for 2 cycles, FIFO empty.
- Push {taken=1, pc=0x40, target=0x80}; resolve not-taken -> flush=1, redirect_pc=0x44, upd_taken=0.
- Push 4 branches, then push a 5th -> full=1, 5th dropped. Four correct resolves yield 4 upd_valid pulses; FIFO empty afterwards.
- res_valid with empty FIFO -> err_underflow=1 and held; no upd_valid. With BR_STATS_EN, the third scenario gives br_count=1, mispred_count=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order check of in-flight direction predictions against execute outcomes,
// producing flush/redirect and predictor training strobes. Define BR_STATS_EN for pop/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            full,
  output logic            stall_fetch,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic            err_underflow
`ifdef BR_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  logic            mem_taken_q [DEPTH];
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_tgt_q   [DEPTH];

  logic            empty_s, full_s, push_s, pop_s, wr_en_s, mispred_s, underflow_s;
  logic            head_taken_s;
  logic [XLEN-1:0] head_pc_s, head_tgt_s;

  logic            flush_q, upd_valid_q, upd_taken_q, err_q;
  logic [XLEN-1:0] redirect_q;

  function automatic logic is_mispredict(input logic pt, input logic [XLEN-1:0] ptgt,
                                         input logic rt, input logic [XLEN-1:0] rtgt);
    return (pt != rt) || (pt && rt && (ptgt != rtgt));
  endfunction

  // Fall-through PC wraps naturally at the XLEN boundary.
  function automatic logic [XLEN-1:0] correct_pc(input logic rt, input logic [XLEN-1:0] rtgt,
                                                 input logic [XLEN-1:0] pc);
    return rt ? rtgt : (pc + XLEN'(4));
  endfunction

  assign empty_s      = (count_q == {CW{1'b0}});
  assign full_s       = (count_q == CW'(DEPTH));
  assign head_taken_s = mem_taken_q[rd_q];
  assign head_pc_s    = mem_pc_q[rd_q];
  assign head_tgt_s   = mem_tgt_q[rd_q];

  assign full          = full_s;
  assign stall_fetch   = (state_q == ST_RECOVER);
  assign flush         = flush_q;
  assign redirect_pc   = redirect_q;
  assign upd_valid     = upd_valid_q;
  assign upd_taken     = upd_taken_q;
  assign err_underflow = err_q;

  // Next-state logic: FIFO bookkeeping, mispredict detection and recovery countdown.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    count_d     = count_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    wr_en_s     = 1'b0;
    mispred_s   = 1'b0;
    underflow_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        push_s      = pred_valid && !full_s;
        pop_s       = res_valid && !empty_s;
        underflow_s = res_valid && empty_s;
        if (pop_s) begin
          mispred_s = is_mispredict(head_taken_s, head_tgt_s, res_taken, res_target);
        end else begin
          mispred_s = 1'b0;
        end
        // A mispredict squashes every younger entry, including this cycle's wrong-path push.
        if (mispred_s) begin
          state_d = ST_RECOVER;
          cnt_d   = KW'(FLUSH_CYCLES);
          wr_d    = {PW{1'b0}};
          rd_d    = {PW{1'b0}};
          count_d = {CW{1'b0}};
        end else begin
          wr_en_s = push_s;
          if (push_s) wr_d = wr_q + PW'(1); else wr_d = wr_q;
          if (pop_s)  rd_d = rd_q + PW'(1); else rd_d = rd_q;
          case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
          endcase
        end
      end
      ST_RECOVER: begin
        if (cnt_q == KW'(1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - KW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, counter and FIFO pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= {KW{1'b0}};
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_taken_q[i] <= 1'b0;
        mem_pc_q[i]    <= {XLEN{1'b0}};
        mem_tgt_q[i]   <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_taken_q[wr_q] <= pred_taken;
      mem_pc_q[wr_q]    <= pred_pc;
      mem_tgt_q[wr_q]   <= pred_target;
    end
  end

  // Registered flush/redirect, training strobes and sticky underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      err_q       <= 1'b0;
      redirect_q  <= {XLEN{1'b0}};
    end else begin
      flush_q     <= mispred_s;
      upd_valid_q <= pop_s;
      upd_taken_q <= pop_s && res_taken;
      if (mispred_s) begin
        redirect_q <= correct_pc(res_taken, res_target, head_pc_s);
      end
      if (underflow_s) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef BR_STATS_EN
  logic [31:0] br_count_q, mispred_count_q;

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      if (pop_s)     br_count_q      <= br_count_q + 32'd1;
      if (mispred_s) mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, reset corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int FC    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_target;
  logic        full, stall_fetch, flush, upd_valid, upd_taken, err_underflow;
  logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
  logic [31:0] br_count, mispred_count;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .full(full), .stall_fetch(stall_fetch), .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .err_underflow(err_underflow)
`ifdef BR_STATS_EN
    , .br_count(br_count), .mispred_count(mispred_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct packed {
    logic        pv, pt;
    logic [31:0] ppc, ptgt;
    logic        rv, rt;
    logic [31:0] rtgt;
    logic        e_full, e_stall, e_flush;
    logic [31:0] e_redir;
    logic        e_upd, e_updt, e_err;
  } vec_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc, target;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  int   m_rec, m_br, m_mis, sz;
  logic m_err, do_push, e_upd, e_updt, e_flush, e_full, e_stall;
  logic [31:0] e_redir;
  ent_t h;

  task automatic drive(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
    pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_stall"}, stall_fetch, 1'b0);
    chk({tag, "_upd"}, upd_valid, 1'b0);
    chk({tag, "_updt"}, upd_taken, 1'b0);
    chk({tag, "_err"}, err_underflow, 1'b0);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_redir"}, redirect_pc, 32'h0);
  endtask

  // Reference model: one clock edge of the spec's behaviour over a plain queue.
  task automatic model_step();
    e_upd = 1'b0; e_updt = 1'b0; e_flush = 1'b0;
    if (m_rec > 0) begin
      m_rec--;
    end else begin
      sz = mq.size();
      do_push = pred_valid && (sz < DEPTH);
      if (res_valid && sz == 0) m_err = 1'b1;
      if (res_valid && sz > 0) begin
        h = mq.pop_front();
        e_upd = 1'b1; e_updt = res_taken; m_br++;
        if (h.taken != res_taken || (h.taken && res_taken && h.target != res_target)) begin
          e_flush = 1'b1;
          e_redir = res_taken ? res_target : h.pc + 32'd4;
          mq.delete();
          m_rec = FC; m_mis++; do_push = 1'b0;
        end
      end
      if (do_push) mq.push_back('{pred_taken, pred_pc, pred_target});
    end
    e_full  = (mq.size() == DEPTH);
    e_stall = (m_rec > 0);
  endtask

  logic [31:0] tgts [3];

  initial begin
    tgts[0] = 32'h1000; tgts[1] = 32'h2000; tgts[2] = 32'h3000;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    // pv pt ppc ptgt rv rt rtgt | full stall flush redir upd updt err
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h100,32'h200,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h200, 1'b0,1'b0,1'b0,32'h0,1'b1,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,32'h100,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h180, 1'b0,1'b1,1'b1,32'h180,1'b1,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h40,32'h80,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b1,1'b0,32'h0, 1'b0,1'b1,1'b1,32'h44,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h300,32'h400,1'b1,1'b1,32'h0, 1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h300,32'h400,1'b1,1'b1,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,32'h10,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,32'h20,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,32'h30,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,32'h40,32'h0,1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,32'h50,32'h0,1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b1,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1});
    tbl.push_back('{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1});

    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptgt, tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
      cyc();
      chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("vec%0d_stall", i), stall_fetch, tbl[i].e_stall);
      chk($sformatf("vec%0d_flush", i), flush, tbl[i].e_flush);
      chk($sformatf("vec%0d_upd", i), upd_valid, tbl[i].e_upd);
      chk($sformatf("vec%0d_updt", i), upd_taken, tbl[i].e_updt);
      chk($sformatf("vec%0d_err", i), err_underflow, tbl[i].e_err);
      if (tbl[i].e_flush) chk($sformatf("vec%0d_redir", i), redirect_pc, tbl[i].e_redir);
    end

    // Reset asserted while flush is high.
    drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h600);
    cyc();
    chk("midflush_flush_pre", flush, 1'b1);
    chk("midflush_redir_pre", redirect_pc, 32'h600);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 rst = 1'b0;
    #1 chk_zero("midflush_rst");
    cyc();
    rst = 1'b1;
    cyc();
    chk_zero("post_rst");

    // Reset asserted mid-RECOVER.
    drive(1'b1, 1'b1, 32'h700, 32'h800, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h900);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    chk("midrec_stall_pre", stall_fetch, 1'b1);
    #1 rst = 1'b0;
    #1 chk_zero("midrec_rst");
    cyc();
    rst = 1'b1;

    // Randomized traffic against the reference model.
    mq.delete(); m_rec = 0; m_br = 0; m_mis = 0; m_err = 1'b0; e_redir = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      pred_valid  = ($urandom_range(0, 99) < 45);
      pred_taken  = $urandom_range(0, 1) == 1;
      pred_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      pred_target = tgts[$urandom_range(0, 2)];
      res_valid   = ($urandom_range(0, 99) < 40);
      if (mq.size() > 0) begin
        res_taken  = ($urandom_range(0, 3) != 0) ? mq[0].taken : ~mq[0].taken;
        res_target = ($urandom_range(0, 3) != 0) ? mq[0].target : tgts[$urandom_range(0, 2)];
      end else begin
        res_taken  = $urandom_range(0, 1) == 1;
        res_target = tgts[$urandom_range(0, 2)];
      end
      model_step();
      cyc();
      chk("rnd_full", full, e_full);
      chk("rnd_stall", stall_fetch, e_stall);
      chk("rnd_flush", flush, e_flush);
      chk("rnd_upd", upd_valid, e_upd);
      chk("rnd_updt", upd_taken, e_updt);
      chk("rnd_err", err_underflow, m_err);
      if (e_flush) chk("rnd_redir", redirect_pc, e_redir);
`ifdef BR_STATS_EN
      chk("rnd_br_count", br_count, m_br);
      chk("rnd_mispred_count", mispred_count, m_mis);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
